// File: rtl/i2c_master_arbiter_if.sv
// Client-side and I2C-master-side signal bundle for i2c_master_arbiter.
// The arbiter connects through "master"; clients and the I2C master through "slave".
`timescale 1ns/1ps
interface i2c_master_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_rw;
    logic [7*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic [1:0]           status;
    logic [7:0]           rdata;
    logic                 m_start;
    logic                 m_rw;
    logic [6:0]           m_addr;
    logic [7:0]           m_wdata;
    logic                 m_busy;
    logic                 m_done;
    logic                 m_nack;
    logic [7:0]           m_rdata;

    modport master (
        input  req, req_rw, req_addr, req_wdata,
        input  m_busy, m_done, m_nack, m_rdata,
        output gnt, done, status, rdata,
        output m_start, m_rw, m_addr, m_wdata
    );

    modport slave (
        output req, req_rw, req_addr, req_wdata,
        output m_busy, m_done, m_nack, m_rdata,
        input  gnt, done, status, rdata,
        input  m_start, m_rw, m_addr, m_wdata
    );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin sharing of one I2C master among NUM_REQ clients, with NACK retry.
// Define I2C_ARB_TIMEOUT_EN to add the WAIT-state watchdog (status 10).
`timescale 1ns/1ps
module i2c_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int RETRY_MAX      = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                  clk,
    input logic                  reset,
    i2c_master_arbiter_if.master bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, idx, win;
    logic          found;
    logic [2:0]    retry_cnt;
    logic          can_retry;
`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0]   tmo_cnt;
    logic          tmo_hit;
    assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`endif

    assign can_retry = bus.m_nack && (retry_cnt < 3'(RETRY_MAX));

    // First active request at or after ptr, wrapping around
    always_comb begin
        int c;
        found = 1'b0;
        win   = '0;
        c     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = (int'(ptr) + k) % NUM_REQ;
            if (!found && bus.req[c]) begin
                found = 1'b1;
                win   = IW'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bus.m_start = 1'b0;
        unique case (state)
            IDLE: if (found) state_nxt = ISSUE;
            ISSUE: begin
                if (!bus.m_busy) begin
                    bus.m_start = 1'b1;
                    state_nxt   = WAIT;
                end
            end
            WAIT: begin
                if (bus.m_done)
                    state_nxt = can_retry ? ISSUE : RESP;
`ifdef I2C_ARB_TIMEOUT_EN
                else if (tmo_hit)
                    state_nxt = RESP;
`endif
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= '0;
            idx         <= '0;
            retry_cnt   <= '0;
            bus.gnt     <= '0;
            bus.done    <= '0;
            bus.status  <= 2'b00;
            bus.rdata   <= '0;
            bus.m_rw    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            bus.done <= '0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        idx         <= win;
                        retry_cnt   <= '0;
                        bus.gnt     <= ONE << win;
                        bus.m_rw    <= bus.req_rw[win];
                        bus.m_addr  <= bus.req_addr[7*int'(win) +: 7];
                        bus.m_wdata <= bus.req_wdata[8*int'(win) +: 8];
                    end
                end
                ISSUE: begin
`ifdef I2C_ARB_TIMEOUT_EN
                    if (!bus.m_busy) tmo_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (bus.m_done) begin
                        if (can_retry) begin
                            retry_cnt <= retry_cnt + 3'd1;
                        end else if (bus.m_nack) begin
                            bus.status    <= 2'b01;
                            bus.done[idx] <= 1'b1;
                        end else begin
                            bus.status    <= 2'b00;
                            bus.rdata     <= bus.m_rw ? bus.m_rdata : 8'h00;
                            bus.done[idx] <= 1'b1;
                        end
`ifdef I2C_ARB_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        bus.status    <= 2'b10;
                        bus.rdata     <= 8'h00;
                        bus.done[idx] <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
`endif
                    end
                end
                RESP: begin
                    bus.gnt <= '0;
                    ptr     <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter: directed requests, modelled I2C master.
// Timeout case runs only when I2C_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_i2c_master_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    i2c_master_arbiter_if #(.NUM_REQ(N)) bus ();

    i2c_master_arbiter #(
        .NUM_REQ(N),
        .RETRY_MAX(2),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int         idx;
        logic [1:0] st;
        logic [7:0] rd;
        int         starts;
    } exp_t;

    typedef struct {
        logic       nack;
        logic [7:0] rd;
        int         dly;
    } rsp_t;

    exp_t sb_q[$];
    rsp_t rsp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int starts = 0;
    int gnt_bad = 0;
    int cyc = 0;
    int last_mdone = -100;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(int i, logic rw, logic [6:0] a, logic [7:0] d);
        bus.req_rw[i]          = rw;
        bus.req_addr[7*i +: 7] = a;
        bus.req_wdata[8*i +: 8] = d;
    endtask

    task automatic wait_done(int n, int budget);
        int t;
        int target;
        t = 0;
        target = n_done + n;
        while (n_done < target && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (n_done < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got %0d done pulses, required %0d",
                     n_done - (target - n), n);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                starts = 0;
            end else begin
                if (!$onehot0(bus.gnt)) gnt_bad++;
                if (bus.m_start) starts++;
                if (bus.done != '0) begin
                    n_done++;
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_done: got %b required none",
                                 bus.done);
                    end else begin
                        e = sb_q.pop_front();
                        chk("done_vec", 32'(bus.done), 32'(1) << e.idx);
                        chk("status", 32'(bus.status), 32'(e.st));
                        chk("rdata", 32'(bus.rdata), 32'(e.rd));
                        chk("start_count", starts, e.starts);
                        if (e.st != 2'b10)
                            chk("done_latency", cyc - last_mdone, 1);
                    end
                    starts = 0;
                end
            end
            if (bus.m_done) last_mdone = cyc;
        end
    end

    // I2C master model: answers each m_start with the next queued response
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (bus.m_start && rsp_q.size() > 0) begin
                r = rsp_q.pop_front();
                @(posedge clk);
                #1;
                bus.m_busy = 1'b1;
                repeat (r.dly) @(posedge clk);
                #1;
                bus.m_busy  = 1'b0;
                bus.m_done  = 1'b1;
                bus.m_nack  = r.nack;
                bus.m_rdata = r.rd;
                @(posedge clk);
                #1;
                bus.m_done = 1'b0;
                bus.m_nack = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        int d0;
        reset         = 1'b1;
        bus.req       = '0;
        bus.req_rw    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.m_busy    = 1'b0;
        bus.m_done    = 1'b0;
        bus.m_nack    = 1'b0;
        bus.m_rdata   = '0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_status", 32'(bus.status), 0);
        chk("rst_rdata", 32'(bus.rdata), 0);
        chk("rst_m_start", 32'(bus.m_start), 0);
        chk("rst_m_rw", 32'(bus.m_rw), 0);
        chk("rst_m_addr", 32'(bus.m_addr), 0);
        chk("rst_m_wdata", 32'(bus.m_wdata), 0);

        // Read from requester 0
        setup(0, 1'b1, 7'h3C, 8'h00);
        rsp_q.push_back('{1'b0, 8'h7E, 5});
        sb_q.push_back('{0, 2'b00, 8'h7E, 1});
        bus.req[0] = 1'b1;
        wait_done(1, 200);
        bus.req[0] = 1'b0;

        // Write from requester 2 with grant timing
        tick();
        setup(2, 1'b0, 7'h50, 8'hA5);
        rsp_q.push_back('{1'b0, 8'hC3, 20});
        sb_q.push_back('{2, 2'b00, 8'h00, 1});
        bus.req[2] = 1'b1;
        @(negedge clk);
        chk("wr_gnt_N", 32'(bus.gnt), 0);
        @(negedge clk);
        chk("wr_gnt_N1", 32'(bus.gnt), 32'b0100);
        chk("wr_m_start", 32'(bus.m_start), 1);
        chk("wr_m_addr", 32'(bus.m_addr), 32'h50);
        chk("wr_m_wdata", 32'(bus.m_wdata), 32'hA5);
        chk("wr_m_rw", 32'(bus.m_rw), 0);
        wait_done(1, 200);
        bus.req[2] = 1'b0;

        // Requester 3: NACK on every attempt
        tick();
        setup(3, 1'b0, 7'h21, 8'h0F);
        repeat (3) rsp_q.push_back('{1'b1, 8'h00, 4});
        sb_q.push_back('{3, 2'b01, 8'h00, 3});
        bus.req[3] = 1'b1;
        wait_done(1, 300);
        bus.req[3] = 1'b0;

        // Fairness: 0, 1, 3 held high, pointer currently at 0
        tick();
        setup(0, 1'b0, 7'h10, 8'h01);
        setup(1, 1'b0, 7'h11, 8'h02);
        setup(3, 1'b0, 7'h13, 8'h03);
        repeat (4) rsp_q.push_back('{1'b0, 8'hFF, 3});
        sb_q.push_back('{0, 2'b00, 8'h00, 1});
        sb_q.push_back('{1, 2'b00, 8'h00, 1});
        sb_q.push_back('{3, 2'b00, 8'h00, 1});
        sb_q.push_back('{0, 2'b00, 8'h00, 1});
        bus.req = 4'b1011;
        wait_done(4, 400);
        bus.req = '0;

        // Requester 1 read: NACK, NACK, ACK
        tick();
        setup(1, 1'b1, 7'h48, 8'h00);
        rsp_q.push_back('{1'b1, 8'h00, 3});
        rsp_q.push_back('{1'b1, 8'h00, 3});
        rsp_q.push_back('{1'b0, 8'h5A, 3});
        sb_q.push_back('{1, 2'b00, 8'h5A, 3});
        bus.req[1] = 1'b1;
        wait_done(1, 300);
        bus.req[1] = 1'b0;

        // Stray m_done while idle
        tick();
        tick();
        d0 = n_done;
        bus.m_done = 1'b1;
        tick();
        bus.m_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_m_done_ignored", n_done, d0);
        chk("idle_gnt", 32'(bus.gnt), 0);

        // Busy master delays the start, then reset mid-WAIT
        tick();
        bus.m_busy = 1'b1;
        setup(2, 1'b0, 7'h11, 8'h22);
        bus.req[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("busy_gnt", 32'(bus.gnt), 32'b0100);
        chk("busy_no_start", 32'(bus.m_start), 0);
        bad = 0;
        repeat (9) begin
            @(negedge clk);
            if (bus.m_start) bad++;
        end
        chk("busy_hold_no_start", bad, 0);
        tick();
        bus.m_busy = 1'b0;
        @(negedge clk);
        chk("busy_release_start", 32'(bus.m_start), 1);
        repeat (3) @(negedge clk);
        chk("wait_gnt_held", 32'(bus.gnt), 32'b0100);
        tick();
        reset   = 1'b1;
        bus.req = 4'b0101;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_gnt", 32'(bus.gnt), 0);
        chk("post_rst_done", 32'(bus.done), 0);
        chk("post_rst_rdata", 32'(bus.rdata), 0);
        chk("post_rst_m_addr", 32'(bus.m_addr), 0);
        chk("post_rst_m_wdata", 32'(bus.m_wdata), 0);
        chk("post_rst_m_start", 32'(bus.m_start), 0);
        rsp_q.push_back('{1'b0, 8'h00, 2});
        rsp_q.push_back('{1'b0, 8'h00, 2});
        sb_q.push_back('{0, 2'b00, 8'h00, 1});
        sb_q.push_back('{2, 2'b00, 8'h00, 1});
        wait_done(1, 200);
        bus.req[0] = 1'b0;
        wait_done(1, 200);
        bus.req[2] = 1'b0;

`ifdef I2C_ARB_TIMEOUT_EN
        begin
            int s;
            int t;
            tick();
            setup(1, 1'b0, 7'h2A, 8'h44);
            sb_q.push_back('{1, 2'b10, 8'h00, 1});
            bus.req[1] = 1'b1;
            s = -1;
            t = 0;
            while (s < 0 && t < 20) begin
                @(negedge clk);
                #1;
                if (bus.m_start) s = cyc;
                t++;
            end
            chk("tmo_start_seen", 32'(s >= 0), 1);
            wait_done(1, 200);
            chk("tmo_done_delay", cyc - s, 65);
            bus.req[1] = 1'b0;
        end
`endif

        repeat (5) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        chk("rsp_drained", rsp_q.size(), 0);
        chk("gnt_onehot", gnt_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
